// File: rtl/spi_reg_ctrl_if.sv
// Signal bundle between user logic, spi_reg_ctrl and spi_master.
// The slave modport is the controller's view; master is the driving side.
interface spi_reg_ctrl_if #(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 8,
  parameter int FRAME_WIDTH = 16
);
  logic                   i_cmd_valid;
  logic                   o_cmd_ready;
  logic                   i_cmd_rd;
  logic [ADDR_WIDTH-1:0]  i_cmd_addr;
  logic [DATA_WIDTH-1:0]  i_cmd_wdata;
  logic                   o_rsp_valid;
  logic                   o_rsp_rd;
  logic [DATA_WIDTH-1:0]  o_rsp_rdata;
  logic                   o_rsp_err;
  logic                   o_busy;
  logic                   o_spi_wr_evt;
  logic                   o_spi_rd_evt;
  logic [FRAME_WIDTH-1:0] o_spi_wr_data;
  logic                   i_spi_rd_evt;
  logic [FRAME_WIDTH-1:0] i_spi_rd_data;
  logic                   i_spi_mcs;

  modport slave (
    input  i_cmd_valid, i_cmd_rd, i_cmd_addr, i_cmd_wdata,
    input  i_spi_rd_evt, i_spi_rd_data, i_spi_mcs,
    output o_cmd_ready, o_rsp_valid, o_rsp_rd, o_rsp_rdata, o_rsp_err, o_busy,
    output o_spi_wr_evt, o_spi_rd_evt, o_spi_wr_data
  );

  modport master (
    output i_cmd_valid, i_cmd_rd, i_cmd_addr, i_cmd_wdata,
    output i_spi_rd_evt, i_spi_rd_data, i_spi_mcs,
    input  o_cmd_ready, o_rsp_valid, o_rsp_rd, o_rsp_rdata, o_rsp_err, o_busy,
    input  o_spi_wr_evt, o_spi_rd_evt, o_spi_wr_data
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Register-access front end for spi_master: queues commands, issues one
// {rw, addr, data} frame at a time and returns one response per command.
module spi_reg_ctrl #(
  parameter int   ADDR_WIDTH      = 7,
  parameter int   DATA_WIDTH      = 8,
  parameter int   FRAME_WIDTH     = 16,
  parameter int   FIFO_DEPTH      = 4,
  parameter logic MCS_VALID_LEVEL = 1'b0,
  parameter int   GAP_CYCLES      = 4,
  parameter int   TIMEOUT_CYCLES  = 4096
) (
  input logic           user_clk,
  input logic           user_rst_n,
  spi_reg_ctrl_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [TO_W-1:0]  TO_LAST_C  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST_C = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT_START, ST_WAIT_DONE, ST_RESP, ST_GAP
  } state_t;

  logic [FRAME_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic                   push_s, pop_s, full_s, empty_s;
  logic [FRAME_WIDTH-1:0] frame_s, head_s;

  state_t                 state_q, state_d;
  logic                   cur_rd_q, cur_rd_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic                   wr_evt_q, wr_evt_d;
  logic                   rd_evt_q, rd_evt_d;
  logic [FRAME_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_rd_q, rsp_rd_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   mcs_act_s, to_hit_s, done_s;
  logic                   rd_data_hi_unused_s;

  // Reads carry no payload, so the data field is forced to zero at packing time.
  assign frame_s = {bus.i_cmd_rd, bus.i_cmd_addr,
                    bus.i_cmd_rd ? {DATA_WIDTH{1'b0}} : bus.i_cmd_wdata};
  assign full_s  = (count_q == DEPTH_C);
  assign empty_s = (count_q == {CNT_W{1'b0}});
  assign push_s  = bus.i_cmd_valid && !full_s;
  assign head_s  = mem_q[rd_ptr_q];

  assign mcs_act_s = (bus.i_spi_mcs == MCS_VALID_LEVEL);
  assign to_hit_s  = (to_cnt_q == TO_LAST_C);
  assign done_s    = cur_rd_q ? bus.i_spi_rd_evt : !mcs_act_s;
  assign rd_data_hi_unused_s = ^bus.i_spi_rd_data[FRAME_WIDTH-1:DATA_WIDTH];

  // Command queue storage, pointers and occupancy.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= {FRAME_WIDTH{1'b0}};
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= frame_s;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Frame sequencing: next state, counters and next output values.
  always_comb begin
    state_d     = state_q;
    pop_s       = 1'b0;
    cur_rd_d    = cur_rd_q;
    to_cnt_d    = to_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    wr_evt_d    = 1'b0;
    rd_evt_d    = 1'b0;
    wr_data_d   = wr_data_q;
    rsp_valid_d = 1'b0;
    rsp_rd_d    = 1'b0;
    rsp_rdata_d = {DATA_WIDTH{1'b0}};
    rsp_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) state_d = ST_ISSUE;
        else          state_d = ST_IDLE;
      end
      ST_ISSUE: begin
        pop_s     = !empty_s;
        wr_data_d = head_s;
        wr_evt_d  = 1'b1;
        rd_evt_d  = head_s[FRAME_WIDTH-1];
        cur_rd_d  = head_s[FRAME_WIDTH-1];
        to_cnt_d  = {TO_W{1'b0}};
        state_d   = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (to_hit_s) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rd_d    = cur_rd_q;
          rsp_err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (mcs_act_s) state_d = ST_WAIT_DONE;
          else           state_d = ST_WAIT_START;
        end
      end
      ST_WAIT_DONE: begin
        // Completion is tested first so it wins over a same-cycle timeout.
        if (done_s) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rd_d    = cur_rd_q;
          rsp_rdata_d = cur_rd_q ? bus.i_spi_rd_data[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};
        end else if (to_hit_s) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rd_d    = cur_rd_q;
          rsp_err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        gap_cnt_d = {GAP_W{1'b0}};
        state_d   = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST_C) state_d = ST_IDLE;
        else gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q     <= ST_IDLE;
      cur_rd_q    <= 1'b0;
      to_cnt_q    <= {TO_W{1'b0}};
      gap_cnt_q   <= {GAP_W{1'b0}};
      wr_evt_q    <= 1'b0;
      rd_evt_q    <= 1'b0;
      wr_data_q   <= {FRAME_WIDTH{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rd_q    <= 1'b0;
      rsp_rdata_q <= {DATA_WIDTH{1'b0}};
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_rd_q    <= cur_rd_d;
      to_cnt_q    <= to_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      wr_evt_q    <= wr_evt_d;
      rd_evt_q    <= rd_evt_d;
      wr_data_q   <= wr_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.o_cmd_ready   = !full_s;
  assign bus.o_busy        = !empty_s || (state_q != ST_IDLE);
  assign bus.o_spi_wr_evt  = wr_evt_q;
  assign bus.o_spi_rd_evt  = rd_evt_q;
  assign bus.o_spi_wr_data = wr_data_q;
  assign bus.o_rsp_valid   = rsp_valid_q;
  assign bus.o_rsp_rd      = rsp_rd_q;
  assign bus.o_rsp_rdata   = rsp_rdata_q;
  assign bus.o_rsp_err     = rsp_err_q;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl with a behavioural spi_master responder
// and a command-level reference of frames and responses.
module tb_spi_reg_ctrl;
  localparam int AW = 7, DW = 8, FW = 16, DEPTH = 4, GAP = 4, TMO = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0, bad = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_reg_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_WIDTH(FW)) bus ();

  spi_reg_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_WIDTH(FW), .FIFO_DEPTH(DEPTH),
    .MCS_VALID_LEVEL(1'b0), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .user_clk(clk), .user_rst_n(rst_n), .bus(bus)
  );

  typedef struct { logic rd; logic [AW-1:0] addr; logic [DW-1:0] wdata; } cmd_t;
  typedef struct { logic rd; logic [DW-1:0] rdata; logic err; int c; } rsp_t;
  typedef struct { logic [FW-1:0] frame; logic rde; int c; } evt_t;

  cmd_t          exp_q[$];
  rsp_t          rsp_q[$];
  evt_t          evt_q[$];
  logic [DW-1:0] ret_q[$];

  function automatic logic [FW-1:0] exp_frame(input cmd_t c);
    logic [DW-1:0] d;
    d = c.rd ? 8'h00 : c.wdata;
    return {c.rd, c.addr, d};
  endfunction

  // Record every event pulse and response seen on the bus.
  rsp_t rec_r;
  evt_t rec_e;
  always @(negedge clk) begin
    if (bus.o_rsp_valid === 1'b1) begin
      rec_r.rd = bus.o_rsp_rd; rec_r.rdata = bus.o_rsp_rdata; rec_r.err = bus.o_rsp_err; rec_r.c = cyc;
      rsp_q.push_back(rec_r);
    end
    if (bus.o_spi_wr_evt === 1'b1) begin
      rec_e.frame = bus.o_spi_wr_data; rec_e.rde = bus.o_spi_rd_evt; rec_e.c = cyc;
      evt_q.push_back(rec_e);
    end
  end

  // spi_master stand-in: mcs frames the transfer, reads return data before mcs rises.
  int            m_min = 1, m_max = 4, m_skip = 0, m_n = 0;
  bit            m_coincide = 1'b0, m_force = 1'b0;
  logic [FW-1:0] m_force_dat = 16'h0000;
  logic          m_rd;
  logic [FW-1:0] m_dat;
  initial begin
    bus.i_spi_mcs = 1'b1; bus.i_spi_rd_evt = 1'b0; bus.i_spi_rd_data = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if (rst_n && bus.o_spi_wr_evt) begin
        m_rd  = bus.o_spi_rd_evt;
        m_dat = m_force ? m_force_dat : FW'($urandom);
        if (m_skip > 0) begin
          m_skip--;
        end else if (m_coincide) begin
          bus.i_spi_mcs = 1'b0;
          for (int i = 0; i < TMO - 1 && rst_n; i++) begin @(posedge clk); #1; end
          bus.i_spi_rd_data = m_dat; bus.i_spi_rd_evt = 1'b1; ret_q.push_back(m_dat[DW-1:0]);
          @(posedge clk); #1;
          bus.i_spi_rd_evt = 1'b0; bus.i_spi_mcs = 1'b1;
        end else begin
          @(posedge clk); #1;
          bus.i_spi_mcs = 1'b0;
          m_n = $urandom_range(m_max, m_min);
          for (int i = 0; i < m_n && rst_n; i++) begin @(posedge clk); #1; end
          if (m_rd && rst_n) begin
            bus.i_spi_rd_data = m_dat; bus.i_spi_rd_evt = 1'b1; ret_q.push_back(m_dat[DW-1:0]);
            @(posedge clk); #1;
            bus.i_spi_rd_evt = 1'b0;
          end
          bus.i_spi_mcs = 1'b1;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_all();
    exp_q.delete(); rsp_q.delete(); evt_q.delete(); ret_q.delete();
  endtask

  task automatic send_cmd(input cmd_t c, output int acc, output bit ok);
    ok = 1'b0; acc = -1;
    bus.i_cmd_valid = 1'b1; bus.i_cmd_rd = c.rd; bus.i_cmd_addr = c.addr; bus.i_cmd_wdata = c.wdata;
    for (int i = 0; i < 20000 && !ok; i++) begin
      if (bus.o_cmd_ready) begin ok = 1'b1; exp_q.push_back(c); end
      @(posedge clk); #1;
      if (ok) acc = cyc;
    end
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && rsp_q.size() < n; i++) step(1);
    ok = (rsp_q.size() >= n);
  endtask

  task automatic test_reset();
    logic [FW+DW+5:0] outs;
    step(3);
    outs = {bus.o_spi_wr_evt, bus.o_spi_rd_evt, bus.o_spi_wr_data, bus.o_rsp_valid,
            bus.o_rsp_rd, bus.o_rsp_rdata, bus.o_rsp_err, bus.o_busy};
    total++; if (outs !== '0) begin bad++; $display("FAIL reset_outs got=%h exp=0", outs); end
    total++; if (bus.o_cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.o_cmd_ready); end
    rst_n = 1'b1;
    step(5);
    total++; if (bus.o_busy !== 1'b0 || evt_q.size() != 0) begin
      bad++; $display("FAIL reset_idle busy=%b evts=%0d exp busy=0 evts=0", bus.o_busy, evt_q.size());
    end
  endtask

  task automatic test_write();
    cmd_t c; int acc; bit ok;
    clear_all(); m_min = 2; m_max = 5;
    c.rd = 1'b0; c.addr = 7'h12; c.wdata = 8'hA5;
    send_cmd(c, acc, ok);
    wait_rsp(1, 500, ok);
    total++; if (!ok || evt_q.size() != 1) begin bad++; $display("FAIL wr_wait rsps=%0d evts=%0d exp 1/1", rsp_q.size(), evt_q.size()); end
    else begin
      total++; if (evt_q[0].c !== acc + 2) begin bad++; $display("FAIL wr_latency got=%0d exp=%0d", evt_q[0].c - acc, 2); end
      total++; if (evt_q[0].frame !== 16'h12A5) begin bad++; $display("FAIL wr_frame got=%h exp=12a5", evt_q[0].frame); end
      total++; if (evt_q[0].rde !== 1'b0) begin bad++; $display("FAIL wr_rdevt got=%b exp=0", evt_q[0].rde); end
      total++; if ({rsp_q[0].rd, rsp_q[0].err, rsp_q[0].rdata} !== 10'h000) begin
        bad++; $display("FAIL wr_rsp got rd=%b err=%b rdata=%h exp 0/0/00", rsp_q[0].rd, rsp_q[0].err, rsp_q[0].rdata);
      end
    end
    step(10);
    total++; if (bus.o_spi_wr_data !== 16'h12A5) begin bad++; $display("FAIL wr_hold got=%h exp=12a5", bus.o_spi_wr_data); end
  endtask

  task automatic test_read();
    cmd_t c; int acc; bit ok;
    clear_all(); m_force = 1'b1; m_force_dat = 16'h003C;
    c.rd = 1'b1; c.addr = 7'h05; c.wdata = 8'hFF;
    send_cmd(c, acc, ok);
    wait_rsp(1, 500, ok);
    m_force = 1'b0;
    total++; if (!ok || evt_q.size() != 1) begin bad++; $display("FAIL rd_wait rsps=%0d evts=%0d exp 1/1", rsp_q.size(), evt_q.size()); end
    else begin
      total++; if (evt_q[0].frame !== 16'h8500 || evt_q[0].rde !== 1'b1) begin
        bad++; $display("FAIL rd_frame got=%h rde=%b exp=8500 rde=1", evt_q[0].frame, evt_q[0].rde);
      end
      total++; if ({rsp_q[0].rd, rsp_q[0].err, rsp_q[0].rdata} !== {1'b1, 1'b0, 8'h3C}) begin
        bad++; $display("FAIL rd_rsp got rd=%b err=%b rdata=%h exp 1/0/3c", rsp_q[0].rd, rsp_q[0].err, rsp_q[0].rdata);
      end
    end
  endtask

  task automatic test_random();
    cmd_t c; int acc, ri, n; bit ok; logic [DW-1:0] er;
    clear_all(); m_min = 1; m_max = 6; n = 16; ri = 0;
    for (int i = 0; i < n; i++) begin
      c.rd = 1'($urandom); c.addr = AW'($urandom); c.wdata = DW'($urandom);
      step($urandom_range(3, 0));
      send_cmd(c, acc, ok);
    end
    wait_rsp(n, 5000, ok);
    step(30);
    total++; if (rsp_q.size() != n || evt_q.size() != n) begin
      bad++; $display("FAIL rand_count rsps=%0d evts=%0d exp=%0d", rsp_q.size(), evt_q.size(), n);
    end
    for (int i = 0; i < n && i < rsp_q.size() && i < evt_q.size(); i++) begin
      c = exp_q[i];
      er = 8'h00;
      if (c.rd) begin er = (ri < ret_q.size()) ? ret_q[ri] : 8'hxx; ri++; end
      total++; if (evt_q[i].frame !== exp_frame(c) || evt_q[i].rde !== c.rd) begin
        bad++; $display("FAIL rand_frame[%0d] got=%h/%b exp=%h/%b", i, evt_q[i].frame, evt_q[i].rde, exp_frame(c), c.rd);
      end
      total++; if (rsp_q[i].rd !== c.rd || rsp_q[i].err !== 1'b0 || rsp_q[i].rdata !== er) begin
        bad++; $display("FAIL rand_rsp[%0d] got rd=%b err=%b rdata=%h exp %b/0/%h", i, rsp_q[i].rd, rsp_q[i].err, rsp_q[i].rdata, c.rd, er);
      end
      if (i > 0) begin
        total++; if (evt_q[i].c - evt_q[i-1].c < GAP + 2) begin
          bad++; $display("FAIL rand_spacing[%0d] got=%0d exp>=%0d", i, evt_q[i].c - evt_q[i-1].c, GAP + 2);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    cmd_t cmds[6]; int sent, low_at; bit ok;
    clear_all(); m_min = 20; m_max = 20; sent = 0; low_at = -1;
    for (int i = 0; i < 6; i++) begin cmds[i].rd = 1'b0; cmds[i].addr = AW'($urandom); cmds[i].wdata = DW'($urandom); end
    bus.i_cmd_valid = 1'b1;
    for (int i = 0; i < 2000 && sent < 6; i++) begin
      bus.i_cmd_rd = cmds[sent].rd; bus.i_cmd_addr = cmds[sent].addr; bus.i_cmd_wdata = cmds[sent].wdata;
      if (bus.o_cmd_ready) begin exp_q.push_back(cmds[sent]); step(1); sent++; end
      else begin if (low_at < 0) low_at = sent; step(1); end
    end
    bus.i_cmd_valid = 1'b0;
    total++; if (low_at != 5) begin bad++; $display("FAIL b2b_ready_drop got=%0d exp=5", low_at); end
    wait_rsp(6, 3000, ok);
    step(30);
    total++; if (rsp_q.size() != 6 || evt_q.size() != 6) begin
      bad++; $display("FAIL b2b_count rsps=%0d evts=%0d exp=6", rsp_q.size(), evt_q.size());
    end
    for (int i = 0; i < 6 && i < rsp_q.size() && i < evt_q.size(); i++) begin
      total++; if (evt_q[i].frame !== exp_frame(cmds[i]) || rsp_q[i].err !== 1'b0 || rsp_q[i].rd !== 1'b0) begin
        bad++; $display("FAIL b2b_order[%0d] got=%h err=%b exp=%h err=0", i, evt_q[i].frame, rsp_q[i].err, exp_frame(cmds[i]));
      end
      if (i > 0) begin
        total++; if (evt_q[i].c - evt_q[i-1].c < GAP + 2) begin
          bad++; $display("FAIL b2b_spacing[%0d] got=%0d exp>=%0d", i, evt_q[i].c - evt_q[i-1].c, GAP + 2);
        end
      end
    end
  endtask

  task automatic test_timeout();
    cmd_t a, b; int acc; bit ok;
    clear_all(); m_min = 2; m_max = 4; m_skip = 1;
    a.rd = 1'b1; a.addr = AW'($urandom); a.wdata = 8'h00;
    b.rd = 1'b0; b.addr = AW'($urandom); b.wdata = DW'($urandom);
    send_cmd(a, acc, ok);
    send_cmd(b, acc, ok);
    wait_rsp(2, TMO + 500, ok);
    total++; if (!ok || evt_q.size() != 2) begin bad++; $display("FAIL to_wait rsps=%0d evts=%0d exp 2/2", rsp_q.size(), evt_q.size()); end
    else begin
      total++; if ({rsp_q[0].rd, rsp_q[0].err, rsp_q[0].rdata} !== {1'b1, 1'b1, 8'h00}) begin
        bad++; $display("FAIL to_rsp got rd=%b err=%b rdata=%h exp 1/1/00", rsp_q[0].rd, rsp_q[0].err, rsp_q[0].rdata);
      end
      total++; if (rsp_q[0].c - evt_q[0].c != TMO) begin bad++; $display("FAIL to_latency got=%0d exp=%0d", rsp_q[0].c - evt_q[0].c, TMO); end
      total++; if (evt_q[1].frame !== exp_frame(b) || rsp_q[1].err !== 1'b0 || rsp_q[1].rd !== 1'b0) begin
        bad++; $display("FAIL to_next got=%h err=%b exp=%h err=0", evt_q[1].frame, rsp_q[1].err, exp_frame(b));
      end
    end
  endtask

  task automatic test_reset_mid();
    cmd_t c; int acc; bit ok; logic [FW+DW+5:0] outs;
    clear_all(); m_min = 40; m_max = 40;
    for (int i = 0; i < 3; i++) begin
      c.rd = 1'b0; c.addr = AW'(7'h40 + i); c.wdata = DW'(8'h11 * (i + 1));
      send_cmd(c, acc, ok);
    end
    for (int i = 0; i < 200 && evt_q.size() == 0; i++) step(1);
    step(10);
    rst_n = 1'b0;
    #1;
    outs = {bus.o_spi_wr_evt, bus.o_spi_rd_evt, bus.o_spi_wr_data, bus.o_rsp_valid,
            bus.o_rsp_rd, bus.o_rsp_rdata, bus.o_rsp_err, bus.o_busy};
    total++; if (outs !== '0) begin bad++; $display("FAIL rstmid_outs got=%h exp=0", outs); end
    total++; if (bus.o_cmd_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", bus.o_cmd_ready); end
    step(3);
    rst_n = 1'b1;
    step(80);
    total++; if (rsp_q.size() != 0 || evt_q.size() != 1) begin
      bad++; $display("FAIL rstmid_silent rsps=%0d evts=%0d exp rsps=0 evts=1", rsp_q.size(), evt_q.size());
    end
    clear_all(); m_min = 2; m_max = 4;
    c.rd = 1'b0; c.addr = 7'h33; c.wdata = 8'h5A;
    send_cmd(c, acc, ok);
    wait_rsp(1, 500, ok);
    total++; if (!ok || evt_q.size() != 1 || evt_q[0].frame !== 16'h335A || rsp_q[0].err !== 1'b0) begin
      bad++; $display("FAIL rstmid_fresh rsps=%0d evts=%0d exp one clean 335a response", rsp_q.size(), evt_q.size());
    end
  endtask

  task automatic test_coincide();
    cmd_t c; int acc; bit ok; logic [DW-1:0] er;
    clear_all(); m_coincide = 1'b1;
    c.rd = 1'b1; c.addr = AW'($urandom); c.wdata = 8'h00;
    send_cmd(c, acc, ok);
    wait_rsp(1, TMO + 500, ok);
    m_coincide = 1'b0;
    total++; if (!ok || evt_q.size() != 1 || ret_q.size() != 1) begin
      bad++; $display("FAIL co_wait rsps=%0d evts=%0d rets=%0d exp 1/1/1", rsp_q.size(), evt_q.size(), ret_q.size());
    end else begin
      er = ret_q[0];
      total++; if ({rsp_q[0].rd, rsp_q[0].err, rsp_q[0].rdata} !== {1'b1, 1'b0, er}) begin
        bad++; $display("FAIL co_rsp got rd=%b err=%b rdata=%h exp 1/0/%h", rsp_q[0].rd, rsp_q[0].err, rsp_q[0].rdata, er);
      end
      total++; if (rsp_q[0].c - evt_q[0].c != TMO) begin bad++; $display("FAIL co_latency got=%0d exp=%0d", rsp_q[0].c - evt_q[0].c, TMO); end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d exp completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_cmd_valid = 1'b0; bus.i_cmd_rd = 1'b0; bus.i_cmd_addr = 7'h00; bus.i_cmd_wdata = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_coincide();
    step(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
Register-access front end sitting directly upstream of spi_master. It queues register read/write commands from user logic and packs each into one {rw, addr, data} frame. It issues the frame to spi_master as write/read events, detects completion from the SPI chip-select and read-return events, and reports one response per command. It handles serialisation, inter-frame gap and timeout, so user logic never drives spi_master directly.

Parameters:
ADDR_WIDTH, 7, register address width.
DATA_WIDTH, 8, register data width.
FRAME_WIDTH, 16, SPI frame width; must equal 1+ADDR_WIDTH+DATA_WIDTH; sets spi_master INPUT_WIDTH and OUTPUT_WIDTH.
FIFO_DEPTH, 4, command queue depth; power of 2, at least 2.
MCS_VALID_LEVEL, 0, active level of the SPI chip-select; matches spi_master.
GAP_CYCLES, 4, idle user_clk cycles forced between frames; at least 1.
TIMEOUT_CYCLES, 4096, maximum cycles from issue to completion before error.

Ports:
user_clk  in  1  single clock for all logic.
user_rst_n  in  1  reset, asynchronous, active-low.
i_cmd_valid  in  1  command request.
o_cmd_ready  out  1  queue not full; a command is accepted when valid&&ready.
i_cmd_rd  in  1  1=register read, 0=register write.
i_cmd_addr  in  ADDR_WIDTH  register address.
i_cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
o_rsp_valid  out  1  one-cycle response pulse.
o_rsp_rd  out  1  response belongs to a read.
o_rsp_rdata  out  DATA_WIDTH  read data; 0 for writes or errors.
o_rsp_err  out  1  command timed out.
o_busy  out  1  queue non-empty or state not IDLE.
o_spi_wr_evt  out  1  to spi_master i_wr_evt.
o_spi_rd_evt  out  1  to spi_master i_rd_evt.
o_spi_wr_data  out  FRAME_WIDTH  to spi_master i_wr_data.
i_spi_rd_evt  in  1  from spi_master o_rd_evt.
i_spi_rd_data  in  FRAME_WIDTH  from spi_master o_rd_data.
i_spi_mcs  in  1  from spi_master mcs.

Behaviour:
- Reset (user_rst_n low, asynchronous): FIFO emptied; state=IDLE; counters=0; all registered outputs=0. o_cmd_ready is combinational !full, so it reads 1 in reset.
- FIFO: push on valid&&ready. Pop only in ISSUE. Push and pop in the same cycle are both honoured. When full, ready=0 and no push occurs; commands stay in order.
- Frame packing: frame={i_cmd_rd, i_cmd_addr, rd ? 0 : i_cmd_wdata}, MSB first.
- IDLE: FIFO non-empty -> ISSUE.
- ISSUE, one cycle: pop the head entry and drive o_spi_wr_data=frame. Assert o_spi_wr_evt=1 for exactly one cycle for every command; also assert o_spi_rd_evt=1 for reads. Clear the timeout counter. Go to WAIT_START.
- Issue latency: with FIFO empty and state IDLE, the event pulse appears 2 cycles after the acceptance edge. o_spi_wr_data holds its value until the next ISSUE.
- WAIT_START: i_spi_mcs==MCS_VALID_LEVEL -> WAIT_DONE.
- WAIT_DONE:
  - Write: i_spi_mcs!=MCS_VALID_LEVEL -> RESP.
  - Read: i_spi_rd_evt -> RESP, capture i_spi_rd_data[DATA_WIDTH-1:0].
  - For reads, an mcs deassert is ignored.
- Timeout: the counter increments in WAIT_START and WAIT_DONE. When it reaches TIMEOUT_CYCLES-1 -> RESP with err=1 and rdata=0. If completion and timeout occur in the same cycle, completion wins (err=0).
- RESP, one cycle: o_rsp_valid=1, with o_rsp_rd, o_rsp_rdata and o_rsp_err valid in that cycle only. There is no backpressure. Go to GAP.
- GAP: count GAP_CYCLES cycles, then IDLE.
- i_spi_rd_evt outside WAIT_DONE-read is ignored.
- Reset mid-frame: all state is discarded and no response is emitted.
- Exactly one response per accepted command, in acceptance order.

Test Plan:
- Write addr 0x12, wdata 0xA5: o_spi_wr_evt pulses 2 cycles after accept with o_spi_wr_data=0x12A5 and o_spi_rd_evt=0. After mcs high->low->high, o_rsp_valid=1 with rd=0, err=0, rdata=0x00.
- Read addr 0x05: both events pulse with frame 0x8500. The model returns i_spi_rd_evt with i_spi_rd_data=0x003C, and the response shows rd=1, rdata=0x3C, err=0.
- Push 6 back-to-back writes with a slow model: o_cmd_ready drops after 4 are queued while the 1st frame is in flight. Exactly 6 responses arrive in order, and event pulses are at least GAP_CYCLES+2 cycles apart.
- Read with the model never asserting mcs: one response with err=1, rdata=0, arriving TIMEOUT_CYCLES cycles after ISSUE. The next queued command then proceeds normally.
- Assert user_rst_n low during WAIT_DONE with 2 commands queued: all outputs read 0 immediately, ready=1, and no response is emitted. A fresh command after release completes normally.
- Read where i_spi_rd_evt coincides with the last timeout cycle: err=0 and the correct rdata are reported.
